button_event_decoder: RTL and testbench
=======================================

Name: button_event_decoder

Overview:
- Consumes the clean, synchronized level produced by the debouncer front end and classifies it into single-cycle user events: press, release, short press, long press and double click.
- Sits between the debouncer and control/UI logic, so downstream logic never does its own edge or duration timing.
- Input is already synchronous to clk; no synchronizer inside.

Parameters:
LONG_CYCLES, 8, consecutive high samples (including the first) that make a press "long"; legal range >= 2
DCLICK_GAP, 6, consecutive low samples after a short release before the click is final; legal range >= 1
CNT_W, $clog2(max(LONG_CYCLES,DCLICK_GAP))+1, counter width (localparam, derived)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clean_in  input  1  debounced, synchronous button level (1 = pressed)
held  output  1  registered copy of clean_in
press_pulse  output  1  one-cycle pulse on each rising edge of clean_in
release_pulse  output  1  one-cycle pulse on each falling edge of clean_in
short_press  output  1  one-cycle pulse: single short click finalized
long_press  output  1  one-cycle pulse: hold reached LONG_CYCLES
double_click  output  1  one-cycle pulse: second short click released inside gap

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - State IDLE, counter 0, previous-sample register 0.
- Edge definitions:
  - rise = clean_in & ~prev.
  - fall = ~clean_in & prev.
  - prev is clean_in registered every cycle.
- All outputs are registered. Each pulse is high for exactly the one cycle following the clock edge that samples the qualifying value (1-cycle latency).
- Pulses are never stretched.
- press_pulse and release_pulse fire on every edge regardless of state.
- State machine (5 states):
  - IDLE:
    - rise -> PRESSED, cnt=1.
  - PRESSED (first press):
    - High sample: cnt+1. When the sample makes cnt == LONG_CYCLES, assert long_press -> LONG_HELD.
    - fall -> WAIT_GAP, cnt=1 (the falling sample counts as low sample 1).
  - LONG_HELD:
    - fall -> IDLE.
    - No short_press or double_click is ever generated from this state.
  - WAIT_GAP:
    - Low sample: cnt+1. When cnt reaches DCLICK_GAP, assert short_press -> IDLE.
    - rise before that -> SECOND, cnt=1.
  - SECOND (second press):
    - High sample: cnt+1. When cnt reaches LONG_CYCLES, assert long_press -> LONG_HELD. The pending click is discarded; no short_press.
    - fall -> assert double_click (same cycle as release_pulse) -> IDLE.
- Counter:
  - Saturates, never wraps.
  - Cleared on every state change not listed above.
- Mutual exclusion:
  - At most one of short_press/long_press/double_click per cycle.
  - short_press and press_pulse never coincide (a sample is either high or low).
- Boundaries:
  - DCLICK_GAP == 1: short_press fires on the falling sample itself, together with release_pulse. Double click is then impossible.
  - clean_in already high at reset release: the first sample is treated as a rise (prev resets to 0), giving press_pulse and entry to PRESSED.
  - Reset asserted mid-sequence: the sequence is abandoned with no pulse emitted; outputs go to 0 asynchronously.
- held tracks prev; its reset value is 0.

Test Plan:
(LONG_CYCLES=8, DCLICK_GAP=6; e<n> = nth sampling edge after stimulus start.)
1. Short click: clean_in high e1–e3, low from e4.
   - press_pulse after e1.
   - release_pulse after e4.
   - short_press after e9.
   - Nothing else.
2. Long press: high e1–e12, low e13.
   - press_pulse after e1.
   - long_press after e8.
   - release_pulse after e13.
   - No short_press or double_click, including 10 further low cycles.
3. Double click: high e1–e2, low e3–e5, high e6–e7, low e8.
   - press_pulse after e1 and e6.
   - release_pulse after e3 and e8.
   - double_click after e8.
   - No short_press.
4. Gap boundary (two runs):
   - Run A: high e1–e2, low e3–e8, high e9. Required: short_press after e8, then press_pulse after e9 starting a fresh first press.
   - Run B: same but high at e8. Required: no short_press; path enters SECOND.
5. Long second press: high e1–e2, low e3–e4, high e5–e12.
   - long_press after e12.
   - No short_press or double_click.
6. Reset mid-press: hold clean_in high, pulse rst_n low during PRESSED for 2 cycles.
   - All outputs 0 immediately.
   - After release, press_pulse on the first sampled edge.
   - long_press after 8 more high samples.

Source files
------------

// File: rtl/button_event_decoder_if.sv
// Signal bundle between the debouncer-facing producer and the button event decoder.
// The producer drives the clean level and the decoder returns the held level and event pulses.
interface button_event_decoder_if;
    logic clean_in;
    logic held;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic double_click;

    modport master (
        output clean_in,
        input  held,
        input  press_pulse,
        input  release_pulse,
        input  short_press,
        input  long_press,
        input  double_click
    );

    modport slave (
        input  clean_in,
        output held,
        output press_pulse,
        output release_pulse,
        output short_press,
        output long_press,
        output double_click
    );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies a debounced, clk-synchronous button level into one-cycle press/release,
// short-press, long-press and double-click pulses. All outputs are registered.
module button_event_decoder #(
    parameter int LONG_CYCLES = 8,
    parameter int DCLICK_GAP  = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    button_event_decoder_if.slave  btn
);
    localparam int MAX_CNT = (LONG_CYCLES > DCLICK_GAP) ? LONG_CYCLES : DCLICK_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(DCLICK_GAP);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_GAP,
        SECOND
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             prev_q;
    logic             press_q;
    logic             release_q;
    logic             short_q;
    logic             long_q;
    logic             dclick_q;
    logic             rise_d;
    logic             fall_d;

    always_comb begin
        rise_d = btn.clean_in & ~prev_q;
        fall_d = ~btn.clean_in & prev_q;
        cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prev_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            dclick_q  <= 1'b0;
        end else begin
            prev_q    <= btn.clean_in;
            press_q   <= rise_d;
            release_q <= fall_d;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            dclick_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (rise_d) begin
                        state_q <= PRESSED;
                        cnt_q   <= CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (fall_d) begin
                        // With a one-sample gap the falling sample itself finalizes the click.
                        if (DCLICK_GAP == 1) begin
                            short_q <= 1'b1;
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= WAIT_GAP;
                            cnt_q   <= CNT_ONE;
                        end
                    end else if (cnt_d == LONG_LIM) begin
                        long_q  <= 1'b1;
                        state_q <= LONG_HELD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                LONG_HELD: begin
                    if (fall_d) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                WAIT_GAP: begin
                    if (rise_d) begin
                        state_q <= SECOND;
                        cnt_q   <= CNT_ONE;
                    end else if (cnt_d == GAP_LIM) begin
                        short_q <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                SECOND: begin
                    if (fall_d) begin
                        dclick_q <= 1'b1;
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                    end else if (cnt_d == LONG_LIM) begin
                        long_q  <= 1'b1;
                        state_q <= LONG_HELD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn.held          = prev_q;
    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;
    assign btn.short_press   = short_q;
    assign btn.long_press    = long_q;
    assign btn.double_click  = dclick_q;
endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder: default-parameter instance plus a
// DCLICK_GAP=1 / LONG_CYCLES=2 instance for the one-sample-gap boundary.
module tb_button_event_decoder;
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] P    = 5'b10000;
    localparam logic [4:0] R    = 5'b01000;
    localparam logic [4:0] S    = 5'b00100;
    localparam logic [4:0] L    = 5'b00010;
    localparam logic [4:0] D    = 5'b00001;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    button_event_decoder_if bus ();
    button_event_decoder_if bus2 ();

    button_event_decoder #(
        .LONG_CYCLES (8),
        .DCLICK_GAP  (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.slave)
    );

    button_event_decoder #(
        .LONG_CYCLES (2),
        .DCLICK_GAP  (1)
    ) dut_gap1 (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] obs1();
        return {bus.held, bus.press_pulse, bus.release_pulse,
                bus.short_press, bus.long_press, bus.double_click};
    endfunction

    function automatic logic [5:0] obs2();
        return {bus2.held, bus2.press_pulse, bus2.release_pulse,
                bus2.short_press, bus2.long_press, bus2.double_click};
    endfunction

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got {held,P,R,S,L,D}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [4:0] exp);
        bus.clean_in = v;
        @(posedge clk);
        #1;
        check(tag, obs1(), {v, exp});
    endtask

    task automatic step2(input string tag, input logic v, input logic [4:0] exp);
        bus2.clean_in = v;
        @(posedge clk);
        #1;
        check(tag, obs2(), {v, exp});
    endtask

    task automatic lows(input string tag, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(tag, 1'b0, NONE);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.clean_in  = 1'b0;
        bus2.clean_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", obs1(), 6'b0);
        check("reset_state_gap1", obs2(), 6'b0);
        rst_n = 1'b1;

        // Short click
        step("t1_e1", 1'b1, P);
        step("t1_e2", 1'b1, NONE);
        step("t1_e3", 1'b1, NONE);
        step("t1_e4", 1'b0, R);
        lows("t1_gap", 4);
        step("t1_e9", 1'b0, S);
        lows("t1_after", 3);

        // Long press
        step("t2_e1", 1'b1, P);
        for (int unsigned i = 2; i <= 7; i++) step("t2_hold", 1'b1, NONE);
        step("t2_e8", 1'b1, L);
        for (int unsigned i = 9; i <= 12; i++) step("t2_hold2", 1'b1, NONE);
        step("t2_e13", 1'b0, R);
        lows("t2_after", 10);

        // Double click
        step("t3_e1", 1'b1, P);
        step("t3_e2", 1'b1, NONE);
        step("t3_e3", 1'b0, R);
        lows("t3_gap", 2);
        step("t3_e6", 1'b1, P);
        step("t3_e7", 1'b1, NONE);
        step("t3_e8", 1'b0, R | D);
        lows("t3_after", 8);

        // Gap boundary A: gap expires exactly, then a fresh first press
        step("t4a_e1", 1'b1, P);
        step("t4a_e2", 1'b1, NONE);
        step("t4a_e3", 1'b0, R);
        lows("t4a_gap", 4);
        step("t4a_e8", 1'b0, S);
        step("t4a_e9", 1'b1, P);
        step("t4a_e10", 1'b0, R);
        lows("t4a_gap2", 4);
        step("t4a_e15", 1'b0, S);
        lows("t4a_after", 2);

        // Gap boundary B: rise one sample before expiry enters SECOND
        step("t4b_e1", 1'b1, P);
        step("t4b_e2", 1'b1, NONE);
        step("t4b_e3", 1'b0, R);
        lows("t4b_gap", 4);
        step("t4b_e8", 1'b1, P);
        step("t4b_e9", 1'b0, R | D);
        lows("t4b_after", 7);

        // Long second press
        step("t5_e1", 1'b1, P);
        step("t5_e2", 1'b1, NONE);
        step("t5_e3", 1'b0, R);
        step("t5_e4", 1'b0, NONE);
        step("t5_e5", 1'b1, P);
        for (int unsigned i = 6; i <= 11; i++) step("t5_hold", 1'b1, NONE);
        step("t5_e12", 1'b1, L);
        step("t5_e13", 1'b1, NONE);
        step("t5_e14", 1'b0, R);
        lows("t5_after", 8);

        // Reset mid-press, then held-high input is seen as a new rise
        step("t6_e1", 1'b1, P);
        step("t6_e2", 1'b1, NONE);
        step("t6_e3", 1'b1, NONE);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_reset", obs1(), 6'b0);
        @(posedge clk);
        #1;
        check("t6_in_reset1", obs1(), 6'b0);
        @(posedge clk);
        #1;
        check("t6_in_reset2", obs1(), 6'b0);
        rst_n = 1'b1;
        step("t6_r1", 1'b1, P);
        for (int unsigned i = 2; i <= 7; i++) step("t6_hold", 1'b1, NONE);
        step("t6_r8", 1'b1, L);
        step("t6_rel", 1'b0, R);
        lows("t6_after", 4);

        // One-sample gap: short press on the falling sample, no double click
        step2("g1_e1", 1'b1, P);
        step2("g1_e2", 1'b0, R | S);
        step2("g1_e3", 1'b1, P);
        step2("g1_e4", 1'b0, R | S);
        step2("g1_e5", 1'b1, P);
        step2("g1_e6", 1'b1, L);
        step2("g1_e7", 1'b0, R);
        step2("g1_e8", 1'b0, NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
